// File: rtl/send_ack_scheduler_pkg.sv
// Shared types and defaults for the send/ack scheduler.
package send_ack_scheduler_pkg;

    localparam int DATA_W_DEF       = 16;
    localparam int N_PERIPH_DEF     = 2;
    localparam int SETUP_CYCLES_DEF = 1;
    localparam int TIMEOUT_DEF      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_REL,
        ST_DONE
    } state_t;

    // Round-robin pick: the pointer's requester if it is asking, else the other one.
    function automatic logic pick_grant(input logic [1:0] valid, input logic rr);
        return valid[rr] ? rr : ~rr;
    endfunction

endpackage

// File: rtl/send_ack_scheduler_if.sv
// Requester and peripheral signals of the send/ack scheduler.
interface send_ack_scheduler_if import send_ack_scheduler_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_PERIPH = N_PERIPH_DEF
) ();

    logic [1:0]          req_valid;
    logic [1:0]          req_dest;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          req_ready;
    logic [DATA_W-1:0]   dado;
    logic [N_PERIPH-1:0] send;
    logic [N_PERIPH-1:0] ack;
    logic                done;
    logic                done_err;
    logic                done_id;
    logic                busy;

    modport master (
        input  req_valid, req_dest, req_data, ack,
        output req_ready, dado, send, done, done_err, done_id, busy
    );

    modport slave (
        output req_valid, req_dest, req_data, ack,
        input  req_ready, dado, send, done, done_err, done_id, busy
    );

endinterface

// File: rtl/send_ack_scheduler_sync_2ff.sv
// Two-flop synchronizer for signals arriving from unrelated clock domains.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/send_ack_scheduler.sv
// Arbitrates two requesters onto the shared dado bus and runs the send/ack
// four-phase handshake with the selected peripheral, aborting on a stall.
//   state | meaning
//   IDLE  | waiting for a request; grant cycle latches data/dest/id
//   SETUP | dado settling, waiting for a stale ack to clear
//   REQ   | send[dest] high, waiting for ack
//   REL   | send low, waiting for ack to drop
//   DONE  | one-cycle completion pulse
module send_ack_scheduler import send_ack_scheduler_pkg::*; #(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int N_PERIPH     = N_PERIPH_DEF,
    parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input logic                  clk,
    input logic                  rst,
    send_ack_scheduler_if.master bus
);

    localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [N_PERIPH-1:0] ack_s;
    logic [DATA_W-1:0]   dado_q;
    logic                rr;
    logic                dest;
    logic                id;
    logic                err;
    logic                grant;
    logic                gnt_idx;
    logic                timeout;
    logic                cnt_last;
    logic                ack_dest;
    logic                setup_met;
    logic [N_PERIPH-1:0] send_w;
    logic [1:0]          req_ready_w;

    sync_2ff #(.W(N_PERIPH)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ack),
        .q   (ack_s)
    );

    assign cnt_last  = (cnt == TO_LAST);
    assign ack_dest  = ack_s[dest];
    assign setup_met = (int'(cnt) >= SETUP_CYCLES - 1);

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        gnt_idx = rr;
        timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst && (|bus.req_valid)) begin
                    grant   = 1'b1;
                    gnt_idx = pick_grant(bus.req_valid, rr);
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_met && !ack_dest) begin
                    state_n = ST_REQ;
                end else if (cnt_last) begin
                    timeout = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_REQ: begin
                if (ack_dest) begin
                    state_n = ST_REL;
                end else if (cnt_last) begin
                    // Still close out the handshake so the peripheral sees send fall.
                    timeout = 1'b1;
                    state_n = ST_REL;
                end
            end
            ST_REL: begin
                if (!ack_dest) begin
                    state_n = ST_DONE;
                end else if (cnt_last) begin
                    timeout = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dado_q <= '0;
            rr     <= 1'b0;
            dest   <= 1'b0;
            id     <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                cnt <= '0;
            end else if ((state inside {ST_SETUP, ST_REQ, ST_REL}) && !cnt_last) begin
                cnt <= cnt + 1'b1;
            end
            if (grant) begin
                dado_q <= gnt_idx ? bus.req_data[2*DATA_W-1:DATA_W] : bus.req_data[DATA_W-1:0];
                dest   <= bus.req_dest[gnt_idx];
                id     <= gnt_idx;
                rr     <= ~gnt_idx;
            end
            if (state == ST_DONE) begin
                err <= 1'b0;
            end else if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        send_w      = '0;
        req_ready_w = '0;
        if (state == ST_REQ) begin
            send_w[dest] = 1'b1;
        end
        if (grant) begin
            req_ready_w[gnt_idx] = 1'b1;
        end
    end

    assign bus.send      = send_w;
    assign bus.req_ready = req_ready_w;
    assign bus.dado      = dado_q;
    assign bus.done      = (state == ST_DONE);
    assign bus.done_err  = (state == ST_DONE) && err;
    assign bus.done_id   = id;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_send_ack_scheduler.sv
// Scoreboard bench for send_ack_scheduler: grants push expectations, a monitor
// checks each done pulse; peripheral models answer the send/ack handshake.
module tb_send_ack_scheduler;

    localparam int DW = 16;
    localparam int NP = 2;
    localparam int TO = 8;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    typedef struct {
        int id;
        int dest;
        int data;
        int err;
        int send_n;
        int busy_n;
    } exp_t;

    logic clk    = 1'b0;
    logic clk_p0 = 1'b0;
    logic clk_p1 = 1'b0;
    logic rst    = 1'b1;
    logic async_mode = 1'b0;
    logic cap_en     = 1'b0;
    logic ack_m [2];

    int n_checks = 0;
    int n_fail   = 0;
    int n_grants = 0;
    int n_done   = 0;
    int mode [2];
    int dly  [2];
    int exp_err  = 0;
    int exp_send = -1;
    int exp_busy = -1;
    int m_rr     = 0;
    int busy_n   = 0;
    int send_n   = 0;

    exp_t        sb[$];
    int          gnt_log[$];
    logic [15:0] exp_cap0[$];
    logic [15:0] exp_cap1[$];

    always #10 clk    = ~clk;
    always #17 clk_p0 = ~clk_p0;
    always #8  clk_p1 = ~clk_p1;

    wire pclk0 = async_mode ? clk_p0 : clk;
    wire pclk1 = async_mode ? clk_p1 : clk;

    send_ack_scheduler_if #(.DATA_W(DW), .N_PERIPH(NP)) bus ();

    assign bus.ack = {ack_m[1], ack_m[0]};

    send_ack_scheduler #(
        .DATA_W       (DW),
        .N_PERIPH     (NP),
        .SETUP_CYCLES (1),
        .TIMEOUT      (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endfunction

    task automatic capture(input int i);
        if (cap_en) begin
            if (i == 0) begin
                chk("cap0_pending", int'(exp_cap0.size() > 0), 1);
                if (exp_cap0.size() > 0) chk("cap0_data", int'(bus.dado), int'(exp_cap0.pop_front()));
            end else begin
                chk("cap1_pending", int'(exp_cap1.size() > 0), 1);
                if (exp_cap1.size() > 0) chk("cap1_data", int'(bus.dado), int'(exp_cap1.pop_front()));
            end
        end
    endtask

    // Peripheral i: raises ack dly[i] of its own edges after seeing send, drops it likewise.
    task automatic periph(input int i);
        int cnt = 0;
        forever begin
            if (i == 0) @(negedge pclk0);
            else        @(negedge pclk1);
            if (mode[i] == M_NEVER) begin
                ack_m[i] = 1'b0;
                cnt = 0;
            end else if (bus.send[i] && !ack_m[i]) begin
                cnt++;
                if (mode[i] == M_STUCK || cnt >= dly[i]) begin
                    ack_m[i] = 1'b1;
                    cnt = 0;
                    capture(i);
                end
            end else if (!bus.send[i] && ack_m[i] && mode[i] == M_NORMAL) begin
                cnt++;
                if (cnt >= dly[i]) begin
                    ack_m[i] = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    initial periph(0);
    initial periph(1);

    // Monitor: grants push expectations, done pulses pop and compare.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                m_rr   = 0;
                busy_n = 0;
                send_n = 0;
            end else begin
                chk("send_onehot", int'($countones(bus.send) <= 1), 1);
                if (bus.req_ready != 2'b00) begin
                    g = bus.req_valid[m_rr] ? m_rr : 1 - m_rr;
                    chk("grant", int'(bus.req_ready), 1 << g);
                    e.id     = g;
                    e.dest   = int'(bus.req_dest[g]);
                    e.data   = int'(bus.req_data[g*DW +: DW]);
                    e.err    = exp_err;
                    e.send_n = exp_send;
                    e.busy_n = exp_busy;
                    sb.push_back(e);
                    if (cap_en) begin
                        if (e.dest == 0) exp_cap0.push_back(16'(e.data));
                        else             exp_cap1.push_back(16'(e.data));
                    end
                    gnt_log.push_back(g);
                    n_grants++;
                    m_rr = 1 - g;
                end
                if (bus.busy) begin
                    busy_n++;
                    chk("inflight_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) chk("dado_stable", int'(bus.dado), sb[0].data);
                    if (bus.send != '0) begin
                        send_n++;
                        if (sb.size() > 0) chk("send_dest", int'(bus.send), 1 << sb[0].dest);
                    end
                end else begin
                    chk("send_idle", int'(bus.send), 0);
                end
                if (bus.done) begin
                    n_done++;
                    chk("done_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("done_id", int'(bus.done_id), e.id);
                        chk("done_err", int'(bus.done_err), e.err);
                        chk("done_dado", int'(bus.dado), e.data);
                        if (e.send_n >= 0) chk("send_cycles", send_n, e.send_n);
                        if (e.busy_n >= 0) chk("busy_cycles", busy_n, e.busy_n);
                    end
                    busy_n = 0;
                    send_n = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_send", int'(bus.send), 0);
        chk("rst_dado", int'(bus.dado), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_done_err", int'(bus.done_err), 0);
        chk("rst_done_id", int'(bus.done_id), 0);
        chk("rst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic start_xfer(input int r, input int d, input logic [15:0] data,
                              input int e_err, input int e_send, input int e_busy);
        int g0;
        int budget;
        @(posedge clk); #1;
        exp_err  = e_err;
        exp_send = e_send;
        exp_busy = e_busy;
        bus.req_dest[r]          = d[0];
        bus.req_data[r*DW +: DW] = data;
        bus.req_valid[r]         = 1'b1;
        g0     = n_grants;
        budget = 0;
        while (n_grants == g0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("grant_wait", int'(n_grants > g0), 1);
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int budget = 0;
        @(negedge clk); #2;
        while ((sb.size() != 0 || bus.busy) && budget < 400) begin
            @(negedge clk); #2;
            budget++;
        end
        chk("idle_wait", int'(sb.size() == 0 && !bus.busy), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int budget;
        int d0;
        bus.req_valid = '0;
        bus.req_dest  = '0;
        bus.req_data  = '0;
        ack_m[0] = 1'b0;
        ack_m[1] = 1'b0;
        mode[0]  = M_NORMAL;
        mode[1]  = M_NORMAL;
        dly[0]   = 3;
        dly[1]   = 3;

        do_reset();

        // Contention: both requesters held valid, grants must alternate from 0.
        gnt_log.delete();
        @(posedge clk); #1;
        exp_err  = 0;
        exp_send = 5;
        exp_busy = 12;
        bus.req_data  = {16'h2222, 16'h1111};
        bus.req_dest  = 2'b10;
        bus.req_valid = 2'b11;
        g0 = n_grants;
        budget = 0;
        while (n_grants < g0 + 4 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        bus.req_valid = 2'b00;
        chk("contention_grants", n_grants - g0, 4);
        wait_idle();
        chk("gnt_log_size", gnt_log.size(), 4);
        if (gnt_log.size() >= 4) begin
            chk("gnt_order0", gnt_log[0], 0);
            chk("gnt_order1", gnt_log[1], 1);
            chk("gnt_order2", gnt_log[2], 0);
            chk("gnt_order3", gnt_log[3], 1);
        end

        // Single transfer to peripheral 1, ack 3 cycles after send.
        cap_en = 1'b1;
        start_xfer(0, 1, 16'hA5C3, 0, 5, 12);
        wait_idle();
        cap_en = 1'b0;
        chk("single_cap_left", exp_cap1.size(), 0);

        // Peripheral never acks: REQ times out, REL closes immediately.
        mode[0] = M_NEVER;
        start_xfer(0, 0, 16'h5A5A, 1, 8, 11);
        wait_idle();
        chk("busy_after_timeout", int'(bus.busy), 0);
        mode[0] = M_NORMAL;

        // Ack stuck high: REL times out, next transfer aborts in SETUP without send.
        mode[1] = M_STUCK;
        start_xfer(1, 1, 16'h0F0F, 1, 3, 13);
        wait_idle();
        start_xfer(0, 1, 16'hF0F0, 1, 0, 9);
        wait_idle();
        mode[1] = M_NORMAL;
        repeat (10) @(posedge clk);

        // Reset while send is high.
        mode[0] = M_NEVER;
        start_xfer(0, 0, 16'hBEEF, 1, -1, -1);
        budget = 0;
        @(negedge clk);
        while (bus.send != 2'b01 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("send_before_rst", int'(bus.send), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_send", int'(bus.send), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_dado", int'(bus.dado), 0);
        chk("async_rst_done", int'(bus.done), 0);
        d0 = n_done;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mode[0] = M_NORMAL;
        repeat (4) @(posedge clk);
        chk("no_done_after_rst", n_done, d0);

        gnt_log.delete();
        @(posedge clk); #1;
        exp_err  = 0;
        exp_send = 5;
        exp_busy = 12;
        bus.req_data  = {16'h7777, 16'h3333};
        bus.req_dest  = 2'b10;
        bus.req_valid = 2'b11;
        g0 = n_grants;
        budget = 0;
        while (n_grants == g0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        bus.req_valid = 2'b00;
        chk("post_rst_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        wait_idle();

        // Peripherals on unrelated clocks, alternating destinations.
        async_mode = 1'b1;
        dly[0] = 1;
        dly[1] = 1;
        cap_en = 1'b1;
        repeat (4) @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            start_xfer(k % 2, k % 2, 16'(16'h3C00 + k * 37), 0, -1, -1);
            wait_idle();
        end
        cap_en = 1'b0;
        chk("async_cap0_left", exp_cap0.size(), 0);
        chk("async_cap1_left", exp_cap1.size(), 0);
        async_mode = 1'b0;

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
